// File: rtl/mul_issue_if.sv
// Handshake bundle between the EXE-stage issue controller and the
// multi-cycle multiplier. The issue controller is the master.
interface mul_issue_if;
  logic        mul_en;
  logic        mul_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic        mul_busy;
  logic        mul_complete;
  logic [63:0] result;

  modport master (
    output mul_en, mul_signed, x, y,
    input  mul_busy, mul_complete, result
  );

  modport slave (
    input  mul_en, mul_signed, x, y,
    output mul_busy, mul_complete, result
  );
endinterface

// File: rtl/mul_issue.sv
// Multiplier issue controller for MULT/MULTU in the EXE stage.
// Issues a one-cycle request, stalls the pipeline while the product is in
// flight, commits the product to HI/LO, handles MTHI/MTLO writes, flush
// cancellation (draining the orphaned product) and a completion watchdog.
module mul_issue #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_signed,
  input  logic [31:0] op_x,
  input  logic [31:0] op_y,
  input  logic        flush,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  mul_issue_if.master mul,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      state_q,      state_d;
  logic            mul_signed_q, mul_signed_d;
  logic [31:0]     x_q,          x_d;
  logic [31:0]     y_q,          y_d;
  logic [31:0]     hi_q,         hi_d;
  logic [31:0]     lo_q,         lo_d;
  logic            err_q,        err_d;
  logic [WD_W-1:0] wdog_q,       wdog_d;

  logic wd_expire;
  logic prod_we;

  // Watchdog fires on the TIMEOUT-th cycle spent waiting for a product.
  assign wd_expire = (wdog_q == WD_W'(TIMEOUT - 1));

  // Product is committed only when it completes for a live (unflushed) MULT.
  assign prod_we = (state_q == S_WAIT) && mul.mul_complete && !flush;

  // Next-state, operand latch, HI/LO update and watchdog logic.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned
    // (which would infer a latch).
    state_d      = state_q;
    mul_signed_d = mul_signed_q;
    x_d          = x_q;
    y_d          = y_q;
    err_d        = err_q;
    wdog_d       = wdog_q;

    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          mul_signed_d = op_signed;
          x_d          = op_x;
          y_d          = op_y;
          wdog_d       = '0;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        state_d = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (mul.mul_complete) begin
          state_d = S_IDLE;
        end else if (flush) begin
          wdog_d  = wdog_q + 1'b1;
          state_d = S_DRAIN;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d  = wdog_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (mul.mul_complete) begin
          state_d = S_IDLE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d  = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The MULT is younger than the WB-stage MTHI/MTLO, so its product wins.
    hi_d = hi_q;
    lo_d = lo_q;
    if (mthi_we) hi_d = mt_data;
    if (mtlo_we) lo_d = mt_data;
    if (prod_we) begin
      hi_d = mul.result[63:32];
      lo_d = mul.result[31:0];
    end
  end

  // State and architectural registers; reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mul_signed_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      state_q      <= state_d;
      mul_signed_q <= mul_signed_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      err_q        <= err_d;
      wdog_q       <= wdog_d;
    end
  end

  // Pipeline hold: issuing, requesting, waiting on a live product, or a new
  // MULT arriving while an orphaned product drains. Released on timeout exit.
  always_comb begin
    stall = !reset && (
              ((state_q == S_IDLE) && op_valid && !flush) ||
              (state_q == S_REQ) ||
              ((state_q == S_WAIT) && !mul.mul_complete && !flush && !wd_expire) ||
              ((state_q == S_DRAIN) && op_valid));
  end

  // The request pulse exists only in REQ, so a busy multiplier is never re-requested.
  assign mul.mul_en     = (state_q == S_REQ);
  assign mul.mul_signed = mul_signed_q;
  assign mul.x          = x_q;
  assign mul.y          = y_q;

  assign hi  = hi_q;
  assign lo  = lo_q;
  assign err = err_q;

endmodule

// File: tb/tb_mul_issue.sv
// Self-checking bench for mul_issue: a behavioural multiplier answers each
// request (busy one cycle, then complete), and HI/LO expectations come from
// plain 64-bit arithmetic on the operands the bench issued.
module tb_mul_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_signed, flush;
  logic [31:0] op_x, op_y;
  logic        mthi_we, mtlo_we;
  logic [31:0] mt_data;
  logic        stall;
  logic [31:0] hi, lo;
  logic        err;

  always #5 clk = ~clk;

  mul_issue_if mif ();

  mul_issue #(.TIMEOUT(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_signed(op_signed),
    .op_x     (op_x),
    .op_y     (op_y),
    .flush    (flush),
    .mthi_we  (mthi_we),
    .mtlo_we  (mtlo_we),
    .mt_data  (mt_data),
    .mul      (mif),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .err      (err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  // Reference product from the architectural definition of MULT/MULTU.
  function automatic logic [63:0] ref_product(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    return 64'(sa * sb);
  endfunction

  // Behavioural multiplier: busy the cycle after the request, complete the next.
  bit          dead    = 1'b0;
  bit          ovr     = 1'b0;
  logic [63:0] ovr_val = '0;
  int          en_cnt  = 0;
  bit          ph      = 1'b0;
  logic [63:0] prod_r  = '0;
  logic        m_busy  = 1'b0;
  logic        m_cmpl  = 1'b0;
  logic [63:0] m_res   = '0;

  assign mif.mul_busy     = m_busy;
  assign mif.mul_complete = m_cmpl;
  assign mif.result       = m_res;

  always @(posedge clk) begin
    m_cmpl <= 1'b0;
    m_res  <= {$urandom, $urandom};
    if (mif.mul_en) begin
      en_cnt <= en_cnt + 1;
      ph     <= 1'b1;
      m_busy <= 1'b1;
      prod_r <= ovr ? ovr_val : ref_product(mif.mul_signed, mif.x, mif.y);
    end else if (ph) begin
      ph     <= 1'b0;
      m_busy <= 1'b0;
      if (!dead) begin
        m_cmpl <= 1'b1;
        m_res  <= prod_r;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One MULT/MULTU from T0 (called in an IDLE cycle) through T4; leaves the
  // bench in T4 so a following call issues back-to-back.
  task automatic run_mult(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input bit mthi_t3, input logic [31:0] md,
                          input bit use_ovr, input logic [63:0] ov, input string tag);
    int          e0;
    logic [63:0] p;
    p       = use_ovr ? ov : ref_product(s, a, b);
    ovr     = use_ovr;
    ovr_val = ov;
    e0      = en_cnt;
    op_valid = 1'b1; op_signed = s; op_x = a; op_y = b; flush = 1'b0;
    #2;
    check({tag, "_t0_stall"}, stall, 1);
    check({tag, "_t0_en"}, mif.mul_en, 0);
    tick();
    #2;
    check({tag, "_t1_en"}, mif.mul_en, 1);
    check({tag, "_t1_stall"}, stall, 1);
    check({tag, "_t1_x"}, mif.x, a);
    check({tag, "_t1_y"}, mif.y, b);
    check({tag, "_t1_sgn"}, mif.mul_signed, s);
    tick();
    #2;
    check({tag, "_t2_en"}, mif.mul_en, 0);
    check({tag, "_t2_stall"}, stall, 1);
    tick();
    if (mthi_t3) begin
      mthi_we = 1'b1;
      mt_data = md;
    end
    #2;
    check({tag, "_t3_stall"}, stall, 0);
    check({tag, "_t3_hi_old"}, hi, hi_m);
    tick();
    mthi_we  = 1'b0;
    op_valid = 1'b0;
    hi_m = p[63:32];
    lo_m = p[31:0];
    #2;
    check({tag, "_t4_hi"}, hi, hi_m);
    check({tag, "_t4_lo"}, lo, lo_m);
    check({tag, "_en_once"}, 64'(en_cnt - e0), 1);
    ovr = 1'b0;
  endtask

  initial begin
    logic [31:0] bnd_a [4];
    logic [31:0] bnd_b [4];
    bit          bnd_s [4];
    logic [31:0] ra, rb;

    reset = 1'b1; op_valid = 1'b1; op_signed = 1'b1; op_x = 32'h1234; op_y = 32'h5678;
    flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
    #3;
    check("rst_stall", stall, 0);
    check("rst_en", mif.mul_en, 0);
    check("rst_sgn", mif.mul_signed, 0);
    check("rst_x", mif.x, 0);
    check("rst_y", mif.y, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_err", err, 0);
    tick();
    tick();
    reset = 1'b0; op_valid = 1'b0;
    tick();

    // Directed products.
    run_mult(1'b1, 32'hFFFFFFFD, 32'd5, 1'b0, '0, 1'b0, '0, "mult_neg");
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFF1);
    run_mult(1'b0, 32'hFFFFFFFF, 32'd2, 1'b0, '0, 1'b0, '0, "multu_a");
    check("multu_a_hi", hi, 32'h00000001);
    check("multu_a_lo", lo, 32'hFFFFFFFE);
    run_mult(1'b0, 32'd3, 32'd4, 1'b0, '0, 1'b0, '0, "multu_b2b");
    check("multu_b2b_hi", hi, 32'h0);
    check("multu_b2b_lo", lo, 32'd12);

    // Boundary operands, then random back-to-back traffic.
    bnd_a = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF};
    bnd_b = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    bnd_s = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++)
      run_mult(bnd_s[i], bnd_a[i], bnd_b[i], 1'b0, '0, 1'b0, '0, "bound");
    for (int i = 0; i < 12; i++)
      run_mult(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, '0, 1'b0, '0, "rand");

    // Flush in T2: product drained and dropped, a MULT arriving in DRAIN waits.
    op_valid = 1'b1; op_signed = 1'b1; op_x = 32'd7; op_y = 32'd9;
    tick();
    #2;
    check("fl_t1_en", mif.mul_en, 1);
    tick();
    flush = 1'b1;
    #2;
    check("fl_t2_stall", stall, 0);
    tick();
    flush = 1'b0;
    ra = $urandom; rb = $urandom;
    op_valid = 1'b1; op_signed = 1'b0; op_x = ra; op_y = rb;
    #2;
    check("fl_drain_stall", stall, 1);
    check("fl_drain_en", mif.mul_en, 0);
    tick();
    #2;
    check("fl_hi_kept", hi, hi_m);
    check("fl_lo_kept", lo, lo_m);
    run_mult(1'b0, ra, rb, 1'b0, '0, 1'b0, '0, "fl_after");

    // MTHI colliding with a product write: the product wins.
    run_mult(1'b1, $urandom, $urandom, 1'b1, 32'hA5A5A5A5, 1'b1, 64'h12345678_9ABCDEF0, "mt_col");
    check("mt_col_hi", hi, 32'h12345678);
    check("mt_col_lo", lo, 32'h9ABCDEF0);
    mthi_we = 1'b1; mt_data = 32'hA5A5A5A5;
    tick();
    mthi_we = 1'b0; hi_m = 32'hA5A5A5A5;
    mtlo_we = 1'b1; mt_data = 32'h5A5A5A5A;
    #2;
    check("mthi_hi", hi, 32'hA5A5A5A5);
    check("mthi_lo_kept", lo, lo_m);
    tick();
    mtlo_we = 1'b0; lo_m = 32'h5A5A5A5A;
    #2;
    check("mtlo_lo", lo, 32'h5A5A5A5A);
    check("mtlo_hi_kept", hi, hi_m);

    // Watchdog: no completion for 15 WAIT cycles.
    dead = 1'b1;
    op_valid = 1'b1; op_signed = 1'b1; op_x = 32'd11; op_y = 32'd13;
    tick();
    tick();
    for (int k = 1; k <= 15; k++) begin
      #2;
      check($sformatf("wd_stall_w%0d", k), stall, (k < 15) ? 1 : 0);
      check($sformatf("wd_err_w%0d", k), err, 0);
      tick();
    end
    op_valid = 1'b0;
    dead = 1'b0;
    #2;
    check("wd_err_set", err, 1);
    check("wd_stall", stall, 0);
    check("wd_hi_kept", hi, hi_m);
    check("wd_lo_kept", lo, lo_m);
    tick();
    run_mult(1'b0, 32'd6, 32'd7, 1'b0, '0, 1'b0, '0, "wd_after");
    check("wd_err_sticky", err, 1);

    // Asynchronous reset during WAIT; the late completion is ignored.
    op_valid = 1'b1; op_signed = 1'b0; op_x = $urandom | 32'h1; op_y = $urandom | 32'h1;
    tick();
    tick();
    #2;
    reset = 1'b1; op_valid = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    check("arst_stall", stall, 0);
    check("arst_en", mif.mul_en, 0);
    check("arst_sgn", mif.mul_signed, 0);
    check("arst_x", mif.x, 0);
    check("arst_y", mif.y, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_err", err, 0);
    tick();
    reset = 1'b0;
    tick();
    #2;
    check("late_cmpl_hi", hi, hi_m);
    check("late_cmpl_lo", lo, lo_m);
    check("late_cmpl_stall", stall, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL time_limit: observed no completion, expected finish before 500000");
    $fatal(1);
  end

endmodule
